// File: rtl/wb_regfile_pkg.sv
// Shared CPU constants and types for the writeback stage and register file.
package wb_regfile_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
    localparam logic [ADDR_W-1:0] REG_SP   = 5'd29;
    localparam logic [ADDR_W-1:0] REG_RA   = 5'd31;

    localparam logic [DATA_W-1:0] NOP_INST = 32'h0000_0000;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] word_t;

    function automatic word_t wb_select(logic memtoreg, word_t memout, word_t aluout);
        return memtoreg ? memout : aluout;
    endfunction

endpackage

// File: rtl/wb_regfile_if.sv
// WB-stage bundle, ID read ports and debug/status signals of the register file.
interface wb_regfile_if;
    import wb_regfile_pkg::*;

    word_t     wb_inst;
    word_t     wb_ALUOUT;
    word_t     wb_MEMOUT;
    reg_addr_t wb_RegisterRd;
    logic      wb_MemtoReg;
    logic      wb_RegWrite;
    reg_addr_t id_RegisterRs;
    reg_addr_t id_RegisterRt;
    word_t     id_ReadData1;
    word_t     id_ReadData2;
    word_t     wb_WriteData;
    logic      wb_WriteEn;
    reg_addr_t dbg_addr;
    word_t     dbg_data;
    word_t     retired;

    modport master (
        output wb_inst, wb_ALUOUT, wb_MEMOUT, wb_RegisterRd, wb_MemtoReg, wb_RegWrite,
        output id_RegisterRs, id_RegisterRt, dbg_addr,
        input  id_ReadData1, id_ReadData2, wb_WriteData, wb_WriteEn, dbg_data, retired
    );

    modport slave (
        input  wb_inst, wb_ALUOUT, wb_MEMOUT, wb_RegisterRd, wb_MemtoReg, wb_RegWrite,
        input  id_RegisterRs, id_RegisterRt, dbg_addr,
        output id_ReadData1, id_ReadData2, wb_WriteData, wb_WriteEn, dbg_data, retired
    );

endinterface

// File: rtl/wb_regfile_gpr_array.sv
// Raw 32x32 GPR storage: one write port, two combinational reads, one registered debug read.
module gpr_array
    import wb_regfile_pkg::*;
#(
    parameter word_t SP_RESET = 32'h0000_2FFC
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      we,
    input  reg_addr_t waddr,
    input  word_t     wdata,
    input  reg_addr_t raddr1,
    input  reg_addr_t raddr2,
    output word_t     rdata1,
    output word_t     rdata2,
    input  reg_addr_t dbg_addr,
    output word_t     dbg_data
);

    word_t regs [NUM_REGS];

    // Stack pointer comes out of reset pointing at the top of data memory.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= (reg_addr_t'(i) == REG_SP) ? SP_RESET : '0;
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) dbg_data <= '0;
        else      dbg_data <= regs[dbg_addr];
    end

    assign rdata1 = regs[raddr1];
    assign rdata2 = regs[raddr2];

endmodule

// File: rtl/wb_regfile.sv
// Writeback mux, register file with write-through bypass, and retired-instruction counter.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter logic [31:0] SP_RESET = 32'h0000_2FFC,
    parameter int          DATA_W   = 32
) (
    input  logic         clk,
    input  logic         rst,
    wb_regfile_if.slave  bus
);

    logic [DATA_W-1:0] wdata;
    logic              wen;
    logic              byp;
    word_t             raw1, raw2;
    word_t             retired_q;

    assign wdata = wb_select(bus.wb_MemtoReg, bus.wb_MEMOUT, bus.wb_ALUOUT);
    assign wen   = bus.wb_RegWrite && (bus.wb_RegisterRd != REG_ZERO);
    // No bypass while in reset, so reads show the freshly cleared array.
    assign byp   = wen && rst;

    assign bus.wb_WriteData = wdata;
    assign bus.wb_WriteEn   = wen;

    gpr_array #(.SP_RESET(SP_RESET)) u_gpr (
        .clk      (clk),
        .rst      (rst),
        .we       (wen),
        .waddr    (bus.wb_RegisterRd),
        .wdata    (wdata),
        .raddr1   (bus.id_RegisterRs),
        .raddr2   (bus.id_RegisterRt),
        .rdata1   (raw1),
        .rdata2   (raw2),
        .dbg_addr (bus.dbg_addr),
        .dbg_data (bus.dbg_data)
    );

    assign bus.id_ReadData1 = (bus.id_RegisterRs == REG_ZERO)                   ? '0    :
                              (byp && bus.id_RegisterRs == bus.wb_RegisterRd)   ? wdata : raw1;
    assign bus.id_ReadData2 = (bus.id_RegisterRt == REG_ZERO)                   ? '0    :
                              (byp && bus.id_RegisterRt == bus.wb_RegisterRd)   ? wdata : raw2;

    // Every non-bubble counts, including stores and branches; wraps silently.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                         retired_q <= '0;
        else if (bus.wb_inst != NOP_INST) retired_q <= retired_q + 32'd1;
    end

    assign bus.retired = retired_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile with an array/counter reference model checked every cycle.
module tb_wb_regfile;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic chk_en = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    wb_regfile_if bus ();

    wb_regfile #(.SP_RESET(32'h0000_2FFC), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Reference model: plain register array, retire count and debug latch.
    logic [31:0] m_rf [32];
    logic [31:0] m_cnt;
    logic [31:0] m_bias = '0;
    logic [31:0] m_dbg;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) m_rf[i] <= (i == 29) ? 32'h0000_2FFC : 32'h0;
            m_cnt <= '0;
            m_dbg <= '0;
        end else begin
            m_dbg <= m_rf[bus.dbg_addr];
            if (bus.wb_inst != 32'h0) m_cnt <= m_cnt + 32'd1;
            if (bus.wb_RegWrite && bus.wb_RegisterRd != 5'd0)
                m_rf[bus.wb_RegisterRd] <= bus.wb_MemtoReg ? bus.wb_MEMOUT : bus.wb_ALUOUT;
        end
    end

    function automatic logic [31:0] exp_wdata();
        return bus.wb_MemtoReg ? bus.wb_MEMOUT : bus.wb_ALUOUT;
    endfunction

    function automatic logic exp_wen();
        return bus.wb_RegWrite && (bus.wb_RegisterRd != 5'd0);
    endfunction

    function automatic logic [31:0] exp_read(logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (rst && exp_wen() && a == bus.wb_RegisterRd) return exp_wdata();
        return m_rf[a];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("mdl_rd1",     bus.id_ReadData1, exp_read(bus.id_RegisterRs));
            check("mdl_rd2",     bus.id_ReadData2, exp_read(bus.id_RegisterRt));
            check("mdl_wdata",   bus.wb_WriteData, exp_wdata());
            check("mdl_wen",     {31'b0, bus.wb_WriteEn}, {31'b0, exp_wen()});
            check("mdl_retired", bus.retired, m_cnt + m_bias);
            check("mdl_dbg",     bus.dbg_data, m_dbg);
        end
    end

    task automatic drv(input logic [31:0] inst, input logic [31:0] alu, input logic [31:0] mem,
                       input logic [4:0] rd, input logic m2r, input logic rw,
                       input logic [4:0] rs, input logic [4:0] rt);
        bus.wb_inst       = inst;
        bus.wb_ALUOUT     = alu;
        bus.wb_MEMOUT     = mem;
        bus.wb_RegisterRd = rd;
        bus.wb_MemtoReg   = m2r;
        bus.wb_RegWrite   = rw;
        bus.id_RegisterRs = rs;
        bus.id_RegisterRt = rt;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] I_ALU = 32'h0109_5020;
    localparam logic [31:0] I_LW  = 32'h8D0A_0004;
    localparam logic [31:0] I_SW  = 32'hAD0A_0004;

    // Ten-instruction mix: 3 bubbles, 2 stores, 5 register writes.
    logic [31:0] seq_inst [10] = '{I_ALU, 32'h0, I_ALU, I_SW, I_ALU, 32'h0, I_SW, I_ALU, 32'h0, I_ALU};
    logic [4:0]  seq_rd   [10] = '{5'd1, 5'd0, 5'd2, 5'd9, 5'd3, 5'd0, 5'd10, 5'd4, 5'd0, 5'd5};
    logic        seq_rw   [10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        drv(32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
        bus.dbg_addr = 5'd0;
        #2 rst = 1'b0;
        #1 chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Reset contents
        drv(32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd29);
        bus.dbg_addr = 5'd5;
        @(negedge clk);
        check("rst_r0",      bus.id_ReadData1, 32'h0);
        check("rst_sp",      bus.id_ReadData2, 32'h0000_2FFC);
        check("rst_retired", bus.retired, 32'h0);
        next_cycle();
        drv(32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 5'd5, 5'd29);
        @(negedge clk);
        check("rst_r5", bus.id_ReadData1, 32'h0);

        // ALU write to $8 with same-cycle bypass on both ports
        next_cycle();
        drv(I_ALU, 32'h1234_5678, 32'h0, 5'd8, 1'b0, 1'b1, 5'd8, 5'd8);
        @(negedge clk);
        check("byp_rd1", bus.id_ReadData1, 32'h1234_5678);
        check("byp_rd2", bus.id_ReadData2, 32'h1234_5678);
        check("byp_wen", {31'b0, bus.wb_WriteEn}, 32'h1);
        next_cycle();
        drv(32'h0, 32'h0, 32'h0, 5'd8, 1'b0, 1'b0, 5'd8, 5'd0);
        @(negedge clk);
        check("commit_r8",   bus.id_ReadData1, 32'h1234_5678);
        check("dbg_r5",      bus.dbg_data, 32'h0);
        check("retired_one", bus.retired, 32'h1);

        // Write to $0 is dropped
        next_cycle();
        drv(I_ALU, 32'hFFFF_FFFF, 32'h0, 5'd0, 1'b0, 1'b1, 5'd0, 5'd8);
        @(negedge clk);
        check("r0_wen",    {31'b0, bus.wb_WriteEn}, 32'h0);
        check("r0_pre",    bus.id_ReadData1, 32'h0);
        check("r0_wdata",  bus.wb_WriteData, 32'hFFFF_FFFF);
        next_cycle();
        drv(32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd8);
        @(negedge clk);
        check("r0_post",   bus.id_ReadData1, 32'h0);
        check("r8_intact", bus.id_ReadData2, 32'h1234_5678);

        // Load result to $31, visible on the debug port two edges later
        next_cycle();
        bus.dbg_addr = 5'd31;
        drv(I_LW, 32'h0000_0010, 32'hCAFE_BABE, 5'd31, 1'b1, 1'b1, 5'd31, 5'd0);
        @(negedge clk);
        check("mem_wdata", bus.wb_WriteData, 32'hCAFE_BABE);
        check("mem_byp",   bus.id_ReadData1, 32'hCAFE_BABE);
        next_cycle();
        drv(32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
        @(negedge clk);
        check("dbg_one_edge", bus.dbg_data, 32'h0);
        next_cycle();
        @(negedge clk);
        check("dbg_r31",       bus.dbg_data, 32'hCAFE_BABE);
        check("retired_three", bus.retired, 32'h3);

        // Mixed sequence: 7 of 10 retire
        for (int k = 0; k < 10; k++) begin
            next_cycle();
            drv(seq_inst[k], 32'h100 + 32'(k), 32'h0, seq_rd[k], 1'b0, seq_rw[k],
                (k > 0) ? seq_rd[k-1] : 5'd8, seq_rd[k]);
        end
        next_cycle();
        drv(32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 5'd5, 5'd9);
        @(negedge clk);
        check("retired_ten", bus.retired, 32'd10);
        check("seq_r5",      bus.id_ReadData1, 32'h109);
        check("seq_r9_none", bus.id_ReadData2, 32'h0);

        // Counter wrap
        next_cycle();
        force dut.retired_q = 32'hFFFF_FFFF;
        m_bias = 32'hFFFF_FFFF - m_cnt;
        #1 release dut.retired_q;
        @(negedge clk);
        check("retired_max", bus.retired, 32'hFFFF_FFFF);
        next_cycle();
        drv(I_SW, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
        next_cycle();
        drv(32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
        @(negedge clk);
        check("retired_wrap", bus.retired, 32'h0);

        // Asynchronous reset mid-cycle
        next_cycle();
        drv(I_ALU, 32'hA5A5_A5A5, 32'h0, 5'd8, 1'b0, 1'b1, 5'd8, 5'd29);
        next_cycle();
        drv(32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 5'd8, 5'd29);
        @(negedge clk);
        check("pre_rst_r8", bus.id_ReadData1, 32'hA5A5_A5A5);
        #2;
        m_bias = '0;
        drv(32'h0, 32'h1111_1111, 32'h0, 5'd8, 1'b0, 1'b1, 5'd8, 5'd29);
        rst = 1'b0;
        #1;
        check("async_rst_r8",  bus.id_ReadData1, 32'h0);
        check("async_rst_sp",  bus.id_ReadData2, 32'h0000_2FFC);
        check("async_rst_cnt", bus.retired, 32'h0);
        check("async_rst_dbg", bus.dbg_data, 32'h0);
        next_cycle();
        @(negedge clk);
        check("rst_blocks_wr", bus.id_ReadData1, 32'h0);
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_byp", bus.id_ReadData1, 32'h1111_1111);
        next_cycle();
        drv(32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 5'd8, 5'd29);
        @(negedge clk);
        check("post_rst_wr", bus.id_ReadData1, 32'h1111_1111);
        check("post_rst_sp", bus.id_ReadData2, 32'h0000_2FFC);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
